// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-wide RS-232 transmitter, LSB first, 8N1 by default.
// Bytes arrive through a tx_vld/tx_rdy handshake. Each bit is held for
// BAUD_CNT_END sclk cycles, and all outputs are registered.
// Optional feature macro UART_TX_PARITY_EN adds an even-parity bit
// after the data bits, which gives an 8E1 frame of 11 bits.
module uart_byte_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int BAUD_CNT_END = CLK_FREQ / BAUD
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (BAUD_CNT_END > 1) ? $clog2(BAUD_CNT_END) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_END - 1);
  // tx_done is registered, so it is armed one cycle before the final stop cycle
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(BAUD_CNT_END - 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       data_q, data_n;
  logic             tx_n, rdy_n, busy_n, done_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // Register the state, the bit timing and all outputs
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      data_q   <= '0;
      rs232_tx <= 1'b1;
      tx_rdy   <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      data_q   <= data_n;
      rs232_tx <= tx_n;
      tx_rdy   <= rdy_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Compute the next state, advance the baud counter and choose the next line level
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data_q;
    tx_n    = rs232_tx;
    rdy_n   = tx_rdy;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    if (state != IDLE) begin
      cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
    end
    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (tx_vld && tx_rdy) begin
          data_n  = tx_data;
          rdy_n   = 1'b0;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^data_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = data_q[idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        done_n = (cnt == CNT_DONE);
        if (bit_end) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          rdy_n   = 1'b1;
          tx_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx. The DUT is built with a short bit period of 8 cycles.
// Compile with +define+UART_TX_PARITY_EN to check the 11-bit parity frame.
module tb_uart_byte_tx;

  localparam int N = 8;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FRAME_CYC = F * N;

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy, rs232_tx, tx_busy, tx_done;

  uart_byte_tx #(.CLK_FREQ(800), .BAUD(100)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy),
    .rs232_tx(rs232_tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits LSB first: start, d0..d7, stop
    logic       par;    // even parity of data
  } vec_t;

  typedef struct {
    logic [10:0] bits;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   frames_done = 0;

  always @(posedge sclk) cyc = cyc + 1;
  always @(negedge sclk) if (tx_done === 1'b1) done_seen = done_seen + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] make_exp(input logic [9:0] fr, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, fr[8:0]};
`else
    return {par & 1'b0, fr};
`endif
  endfunction

  // Called right after a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic par,
                      input bit hold, output int w);
    tx_data = d;
    tx_vld  = 1'b1;
    w = 0;
    while (tx_rdy !== 1'b1 && w <= FRAME_CYC + 20) begin
      @(negedge sclk);
      w++;
    end
    if (tx_rdy !== 1'b1) begin
      check("accept_timeout", 0, 1);
      tx_vld = 1'b0;
      return;
    end
    sb.push_back('{bits: make_exp(fr, par), hs: cyc + 1});
    @(posedge sclk);
    @(negedge sclk);
    if (!hold) tx_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (tx_rdy !== 1'b1 && w <= FRAME_CYC + 20) begin
      @(negedge sclk);
      w++;
    end
    check("idle_reached", tx_rdy, 1);
  endtask

  // Monitor: checks every line cycle of each frame against the scoreboard entry
  initial begin
    exp_t e;
    int   bad_bits, bad_ctl, bad_done;
    bit   aborted;
    forever begin
      @(negedge sclk);
      if (s_rst_n === 1'b1 && rs232_tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          e = '{bits: '0, hs: -1};
        end else begin
          e = sb.pop_front();
        end
        check("start_latency", cyc, e.hs);
        bad_bits = 0; bad_ctl = 0; bad_done = 0; aborted = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge sclk);
          if (s_rst_n !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (rs232_tx !== e.bits[i / N]) bad_bits++;
          if (tx_busy !== 1'b1 || tx_rdy !== 1'b0) bad_ctl++;
          if (tx_done !== (i == FRAME_CYC - 1)) bad_done++;
        end
        if (!aborted) begin
          check("frame_bits", bad_bits, 0);
          check("frame_busy_rdy", bad_ctl, 0);
          check("frame_done_pulse", bad_done, 0);
          @(negedge sclk);
          check("post_line", rs232_tx, 1);
          check("post_busy", tx_busy, 0);
          check("post_rdy", tx_rdy, 1);
          check("post_done", tx_done, 0);
          frames_done++;
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   w;
    vecs[0] = '{data: 8'h55, frame: 10'b1010101010, par: 1'b0};
    vecs[1] = '{data: 8'h07, frame: 10'b1000001110, par: 1'b1};
    vecs[2] = '{data: 8'h03, frame: 10'b1000000110, par: 1'b0};
    vecs[3] = '{data: 8'h81, frame: 10'b1100000010, par: 1'b0};
    vecs[4] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
    vecs[5] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};

    s_rst_n = 1'b0;
    tx_vld  = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge sclk);
    check("rst_line", rs232_tx, 1);
    check("rst_rdy", tx_rdy, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    s_rst_n = 1'b1;
    #1 check("rdy_before_edge", tx_rdy, 0);
    @(negedge sclk);
    check("rdy_after_release", tx_rdy, 1);

    for (int k = 0; k < 6; k++) begin
      send(vecs[k].data, vecs[k].frame, vecs[k].par, 1'b0, w);
      wait_idle();
    end

    // Back-to-back: tx_vld held high, data changes while frame 1 is on the line
    send(8'hA5, 10'b1101001010, 1'b0, 1'b1, w);
    send(8'h3C, 10'b1001111000, 1'b0, 1'b1, w);
    check("b2b_wait_cycles", w, FRAME_CYC);
    tx_vld = 1'b0;
    wait_idle();

    // A tx_vld pulse mid-frame is ignored
    send(8'hF0, 10'b1111100000, 1'b0, 1'b0, w);
    repeat (2 * N) @(negedge sclk);
    tx_data = 8'h0F;
    tx_vld  = 1'b1;
    @(negedge sclk);
    tx_vld  = 1'b0;
    check("rdy_low_midframe", tx_rdy, 0);
    wait_idle();
    repeat (3 * N) @(negedge sclk);

    // Reset during data bit 3 (a 0 bit of 0xA5) aborts the frame
    send(8'hA5, 10'b1101001010, 1'b0, 1'b0, w);
    repeat (4 * N + 3) @(negedge sclk);
    check("pre_reset_line", rs232_tx, 0);
    #2 s_rst_n = 1'b0;
    #1;
    check("abort_line", rs232_tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_rdy", tx_rdy, 0);
    check("abort_done", tx_done, 0);
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    @(negedge sclk);
    send(8'h00, 10'b1000000000, 1'b0, 1'b0, w);
    wait_idle();
    repeat (4) @(negedge sclk);

    check("frames_completed", frames_done, 10);
    check("done_pulses", done_seen, 10);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
